// File: rtl/booth_div_pkg.sv
// Shared types and constants for the sequential booth divider.
// The default width matches the companion booth multiplier.
package booth_div_pkg;

  localparam int unsigned DefaultWidth = 9;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StSign,
    StDone
  } div_state_e;

  // Counter width able to hold 2*width iteration indices.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(2 * w + 1);
  endfunction

endpackage

// File: rtl/booth_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor magnitude when it fits.
module booth_div_step
  import booth_div_pkg::*;
#(
  parameter int unsigned width = DefaultWidth
) (
  input  logic [width:0] part_rem,
  input  logic           next_bit,
  input  logic [width:0] dvs_mag,
  output logic [width:0] new_rem,
  output logic           q_bit
);

  logic [width+1:0] shifted;

  assign shifted = {part_rem, next_bit};
  assign q_bit   = (shifted >= {1'b0, dvs_mag});
  // When q_bit is set the difference is below dvs_mag, so width+1 bits suffice.
  assign new_rem = q_bit ? (shifted[width:0] - dvs_mag) : shifted[width:0];

endmodule

// File: rtl/booth_divider_seq.sv
// Sequential signed restoring divider: 2*width-bit dividend by width-bit divisor.
// Optional DIV_ZERO_BYPASS_EN: a zero dividend completes in one cycle.
module booth_divider_seq
  import booth_div_pkg::*;
#(
  parameter int unsigned width = DefaultWidth
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*width-1:0]   dividend,
  input  logic [width-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [width-1:0]     quotient,
  output logic [width-1:0]     remainder,
  output logic                 ovf,
  output logic                 div0
);

  localparam int unsigned CntW = cnt_width(width);
  localparam logic [CntW-1:0] LastCnt = CntW'(2 * width - 1);
  localparam logic [2*width-1:0] QLim = {{width{1'b0}}, 1'b1, {(width - 1){1'b0}}};

  div_state_e           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*width-1:0]   dq_q, dq_d;
  logic [width:0]       rem_q, rem_d;
  logic [width:0]       dvs_q, dvs_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic [width-1:0]     quotient_q, quotient_d;
  logic [width-1:0]     remainder_q, remainder_d;
  logic                 ovf_q, ovf_d;
  logic                 div0_q, div0_d;

  logic [2*width-1:0]   dvd_mag;
  logic [width:0]       dvs_ext;
  logic [width:0]       dvs_mag;
  logic [width:0]       step_rem;
  logic                 step_bit;

  assign dvd_mag = dividend[2*width-1] ? (~dividend + 1'b1) : dividend;
  assign dvs_ext = {divisor[width-1], divisor};
  assign dvs_mag = divisor[width-1] ? (~dvs_ext + 1'b1) : dvs_ext;

  // dq_q shifts dividend bits out the top and quotient bits in the bottom.
  booth_div_step #(
    .width(width)
  ) u_step (
    .part_rem(rem_q),
    .next_bit(dq_q[2*width-1]),
    .dvs_mag (dvs_q),
    .new_rem (step_rem),
    .q_bit   (step_bit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dq_d        = dq_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ovf_d       = ovf_q;
    div0_d      = div0_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          qneg_d = dividend[2*width-1] ^ divisor[width-1];
          rneg_d = dividend[2*width-1];
          dq_d   = dvd_mag;
          dvs_d  = dvs_mag;
          rem_d  = '0;
          cnt_d  = '0;
          ovf_d  = 1'b0;
          div0_d = 1'b0;
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend[width-1:0];
            div0_d      = 1'b1;
            state_d     = StDone;
          end
`ifdef DIV_ZERO_BYPASS_EN
          else if (dividend == '0) begin
            quotient_d  = '0;
            remainder_d = '0;
            state_d     = StDone;
          end
`endif
          else begin
            state_d = StIter;
          end
        end
      end
      StIter: begin
        rem_d = step_rem;
        dq_d  = {dq_q[2*width-2:0], step_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) state_d = StSign;
      end
      StSign: begin
        quotient_d  = qneg_q ? (~dq_q[width-1:0] + 1'b1) : dq_q[width-1:0];
        remainder_d = rneg_q ? (~rem_q[width-1:0] + 1'b1) : rem_q[width-1:0];
        // Negative results may reach -2^(width-1); positive ones stop one short.
        ovf_d       = qneg_q ? (dq_q > QLim) : (dq_q >= QLim);
        state_d     = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dq_q        <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dq_q        <= dq_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ovf_q       <= ovf_d;
      div0_q      <= div0_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ovf       = ovf_q;
  assign div0      = div0_q;

endmodule
